cameralink_pixel_packer: RTL and testbench

- Sits directly downstream of the Camera Link medium/base PHY, in the sys_clk domain.
- Takes the 48-bit unpacked pixel words (4 or 2 x 12-bit), repacks them into 64-bit AXI-Stream beats (4 x 16-bit pixels) for the DMA.
- Marks start of frame on tuser and end of line on tlast; tracks line and frame progress.
- Upstream has no backpressure, so an internal FIFO absorbs DMA stalls and reports overflow.

---
 rtl/cameralink_pixel_packer_if.sv | 12 +
 rtl/cameralink_pixel_packer.sv | 222 ++++++++++++++++++++++
 tb/tb_cameralink_pixel_packer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cameralink_pixel_packer_if.sv
// AXI-Stream beat bus carrying packed pixel beats from the packer to the DMA.
interface cameralink_pixel_packer_if;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tvalid;
   logic        tready;
   logic        tlast;
   logic        tuser;

   modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/cameralink_pixel_packer.sv
// Repacks 12-bit Camera Link pixel groups into 64-bit AXI-Stream beats (4 x 16-bit lanes)
// behind a first-word fall-through FIFO that absorbs DMA stalls.
module cameralink_pixel_packer #(
   parameter int FIFO_DEPTH = 16,
   parameter bit MSB_ALIGN  = 1'b0
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   input  logic                      cameraSel,
   input  logic [15:0]               lineWidth,
   input  logic [47:0]               pixel_data_i,
   input  logic                      pixel_vld,
   input  logic                      new_frame,
   input  logic                      frame_valid,
   input  logic                      clr_status,
   cameralink_pixel_packer_if.master m_axis,
   output logic                      frame_done,
   output logic [15:0]               line_count,
   output logic                      overflow,
   output logic                      line_err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = 74;
   localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);

   typedef enum logic {S_EMPTY = 1'b0, S_HALF = 1'b1} acc_state_t;
   acc_state_t r_state, w_state_nxt;

   logic          r_medium;
   logic [15:0]   r_width;
   logic [16:0]   r_pix_cnt;
   logic [31:0]   r_acc_lo;
   logic [15:0]   r_line_cnt;
   logic          r_sof;
   logic          r_fv_d;
   logic          r_frame_done;
   logic          r_overflow;
   logic          r_line_err;
   logic [EW-1:0] r_mem [FIFO_DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;

   logic          w_medium;
   logic          w_half;
   logic [15:0]   w_lw;
   logic [16:0]   w_width;
   logic [16:0]   w_cnt_base;
   logic [17:0]   w_cnt_sum;
   logic          w_line_end;
   logic [15:0]   w_lc_base;
   logic          w_fv_fall;
   logic [63:0]   w_pix_lanes;
   logic          w_push;
   logic [63:0]   w_push_data;
   logic [7:0]    w_push_keep;
   logic          w_push_last;
   logic          w_push_user;
   logic [16:0]   w_cnt_nxt;
   logic [15:0]   w_lc_nxt;
   logic [31:0]   w_acc_lo_nxt;
   logic          w_err_set;
   logic [AW:0]   w_count;
   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_wr_en;
   logic          w_drop;
   logic [EW-1:0] w_head;

   function automatic logic [15:0] f_lane(input logic [11:0] pix);
      if (MSB_ALIGN) begin
         return {pix, 4'h0};
      end else begin
         return {4'h0, pix};
      end
   endfunction

   assign w_pix_lanes = {f_lane(pixel_data_i[47:36]), f_lane(pixel_data_i[35:24]),
                         f_lane(pixel_data_i[23:12]), f_lane(pixel_data_i[11:0])};
   assign w_fv_fall   = r_fv_d & ~frame_valid;

   // A new_frame in the same cycle as pixel_vld takes effect first, so the
   // frame-scoped values below are selected from the incoming pulse.
   always_comb begin
      w_medium     = new_frame ? cameraSel : r_medium;
      w_lw         = new_frame ? lineWidth : r_width;
      w_width      = (w_lw == 16'h0) ? 17'h10000 : {1'b0, w_lw};
      w_half       = ~new_frame & (r_state == S_HALF);
      w_cnt_base   = new_frame ? 17'h0 : r_pix_cnt;
      w_lc_base    = new_frame ? 16'h0 : r_line_cnt;
      w_cnt_sum    = {1'b0, w_cnt_base} + (w_medium ? 18'd4 : 18'd2);
      w_line_end   = (w_cnt_sum >= {1'b0, w_width});
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_pix_cnt;
      w_lc_nxt     = r_line_cnt;
      w_acc_lo_nxt = r_acc_lo;
      w_push       = 1'b0;
      w_push_data  = 64'h0;
      w_push_keep  = 8'h00;
      w_push_last  = 1'b0;
      w_push_user  = new_frame | r_sof;
      w_err_set    = new_frame & (r_state == S_HALF);
      if (pixel_vld) begin
         w_push       = w_medium | w_half | w_line_end;
         w_push_last  = w_line_end;
         w_acc_lo_nxt = w_pix_lanes[31:0];
         if (w_medium) begin
            w_push_data = w_pix_lanes;
            w_push_keep = 8'hFF;
         end else if (w_half) begin
            w_push_data = {w_pix_lanes[31:0], r_acc_lo};
            w_push_keep = 8'hFF;
         end else begin
            w_push_data = {32'h0, w_pix_lanes[31:0]};
            w_push_keep = 8'h0F;
         end
         w_state_nxt = (~w_medium & ~w_half & ~w_line_end) ? S_HALF : S_EMPTY;
         if (w_line_end) begin
            w_cnt_nxt = 17'h0;
            w_lc_nxt  = (w_lc_base == 16'hFFFF) ? w_lc_base : w_lc_base + 16'd1;
         end else begin
            w_cnt_nxt = w_cnt_sum[16:0];
            w_lc_nxt  = w_lc_base;
         end
      end else if (w_fv_fall) begin
         w_state_nxt = S_EMPTY;
         w_cnt_nxt   = 17'h0;
         w_lc_nxt    = w_lc_base;
         if (w_half) begin
            w_push      = 1'b1;
            w_push_data = {32'h0, r_acc_lo};
            w_push_keep = 8'h0F;
            w_push_last = 1'b1;
            w_err_set   = 1'b1;
         end else begin
            w_push      = 1'b0;
         end
      end else begin
         w_state_nxt = w_half ? S_HALF : S_EMPTY;
         w_cnt_nxt   = w_cnt_base;
         w_lc_nxt    = w_lc_base;
      end
   end

   // FIFO occupancy and handshake; a pop frees the slot a full-FIFO push reuses.
   always_comb begin
      w_count = r_wr_ptr - r_rd_ptr;
      w_empty = (w_count == {(AW+1){1'b0}});
      w_full  = (w_count == DEPTH_V);
      w_pop   = ~w_empty & m_axis.tready;
      w_wr_en = w_push & (~w_full | w_pop);
      w_drop  = w_push & w_full & ~w_pop;
      w_head  = r_mem[r_rd_ptr[AW-1:0]];
   end

   assign m_axis.tvalid = ~w_empty;
   assign m_axis.tdata  = w_empty ? 64'h0 : w_head[63:0];
   assign m_axis.tkeep  = w_empty ? 8'h00 : w_head[71:64];
   assign m_axis.tlast  = ~w_empty & w_head[72];
   assign m_axis.tuser  = ~w_empty & w_head[73];
   assign frame_done    = r_frame_done;
   assign line_count    = r_line_cnt;
   assign overflow      = r_overflow;
   assign line_err      = r_line_err;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_medium     <= 1'b1;
         r_width      <= 16'h0;
         r_pix_cnt    <= 17'h0;
         r_acc_lo     <= 32'h0;
         r_line_cnt   <= 16'h0;
         r_sof        <= 1'b0;
         r_fv_d       <= 1'b0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
         r_line_err   <= 1'b0;
      end else begin
         if (new_frame) begin
            r_medium <= cameraSel;
            r_width  <= lineWidth;
         end
         r_pix_cnt    <= w_cnt_nxt;
         r_acc_lo     <= w_acc_lo_nxt;
         r_line_cnt   <= w_lc_nxt;
         r_sof        <= w_push ? 1'b0 : (new_frame | r_sof);
         r_fv_d       <= frame_valid;
         r_frame_done <= w_fv_fall;
         r_overflow   <= (r_overflow & ~clr_status) | w_drop;
         r_line_err   <= (r_line_err & ~clr_status) | w_err_set;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_wr_ptr <= {(AW+1){1'b0}};
         r_rd_ptr <= {(AW+1){1'b0}};
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   // Storage needs no reset: the output fields are masked while the FIFO is empty.
   always_ff @(posedge sys_clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {w_push_user, w_push_last, w_push_keep, w_push_data};
      end
   end
endmodule

// File: tb/tb_cameralink_pixel_packer.sv
// Directed bench for cameralink_pixel_packer with hand-computed expected beats.
module tb_cameralink_pixel_packer;
   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        cameraSel;
   logic [15:0] lineWidth;
   logic [47:0] pixel_data_i;
   logic        pixel_vld;
   logic        new_frame;
   logic        frame_valid;
   logic        clr_status;
   logic        frame_done;
   logic [15:0] line_count;
   logic        overflow;
   logic        line_err;
   int          n_checks = 0;
   int          n_errors = 0;

   cameralink_pixel_packer_if axis ();

   cameralink_pixel_packer #(.FIFO_DEPTH(16), .MSB_ALIGN(1'b0)) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .cameraSel    (cameraSel),
      .lineWidth    (lineWidth),
      .pixel_data_i (pixel_data_i),
      .pixel_vld    (pixel_vld),
      .new_frame    (new_frame),
      .frame_valid  (frame_valid),
      .clr_status   (clr_status),
      .m_axis       (axis),
      .frame_done   (frame_done),
      .line_count   (line_count),
      .overflow     (overflow),
      .line_err     (line_err)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [47:0] px4(input int k);
      logic [11:0] a;
      a = 12'(4 * k + 1);
      return {a + 12'd3, a + 12'd2, a + 12'd1, a};
   endfunction

   function automatic logic [63:0] med_beat(input int k);
      logic [11:0] a;
      a = 12'(4 * k + 1);
      return {4'h0, a + 12'd3, 4'h0, a + 12'd2, 4'h0, a + 12'd1, 4'h0, a};
   endfunction

   initial begin
      sys_rst = 1'b1; cameraSel = 1'b1; lineWidth = 16'd0; pixel_data_i = 48'h0;
      pixel_vld = 1'b0; new_frame = 1'b0; frame_valid = 1'b0; clr_status = 1'b0;
      axis.tready = 1'b1;
      tick(); tick();
      check("rst_tvalid", axis.tvalid, 64'h0);
      check("rst_tdata", axis.tdata, 64'h0);
      check("rst_line_count", line_count, 64'h0);
      check("rst_flags", {overflow, line_err, frame_done}, 64'h0);
      sys_rst = 1'b0;
      tick();

      // Medium mode, width 8, two lines of two beats
      frame_valid = 1'b1; new_frame = 1'b1; cameraSel = 1'b1; lineWidth = 16'd8;
      tick();
      new_frame = 1'b0; pixel_vld = 1'b1; pixel_data_i = px4(0);
      tick();
      check("m_b0_tvalid", axis.tvalid, 64'h1);
      check("m_b0_tdata", axis.tdata, 64'h0004_0003_0002_0001);
      check("m_b0_user_last_keep", {axis.tuser, axis.tlast, axis.tkeep}, {54'h0, 1'b1, 1'b0, 8'hFF});
      pixel_data_i = px4(1);
      tick();
      check("m_b1_tdata", axis.tdata, 64'h0008_0007_0006_0005);
      check("m_b1_user_last_keep", {axis.tuser, axis.tlast, axis.tkeep}, {54'h0, 1'b0, 1'b1, 8'hFF});
      check("m_line_count1", line_count, 64'd1);
      pixel_data_i = px4(2);
      tick();
      check("m_b2_tdata", axis.tdata, 64'h000C_000B_000A_0009);
      check("m_b2_last", axis.tlast, 64'h0);
      pixel_data_i = px4(3);
      tick();
      check("m_b3_tdata", axis.tdata, 64'h0010_000F_000E_000D);
      check("m_b3_user_last_keep", {axis.tuser, axis.tlast, axis.tkeep}, {54'h0, 1'b0, 1'b1, 8'hFF});
      pixel_vld = 1'b0;
      tick();
      check("m_drained", axis.tvalid, 64'h0);
      check("m_line_count2", line_count, 64'd2);
      check("m_fdone_early", frame_done, 64'h0);
      frame_valid = 1'b0;
      tick();
      check("m_fdone_pulse", frame_done, 64'h1);
      tick();
      check("m_fdone_clear", frame_done, 64'h0);
      check("m_line_err", line_err, 64'h0);

      // Base mode, width 6, one line ending on a half beat
      frame_valid = 1'b1; new_frame = 1'b1; cameraSel = 1'b0; lineWidth = 16'd6;
      tick();
      new_frame = 1'b0; pixel_vld = 1'b1; pixel_data_i = 48'hDEF_ABC_102_101;
      tick();
      check("b_no_beat_yet", axis.tvalid, 64'h0);
      pixel_data_i = 48'h555_AAA_104_103;
      tick();
      check("b_b0_tdata", axis.tdata, 64'h0104_0103_0102_0101);
      check("b_b0_user_last_keep", {axis.tvalid, axis.tuser, axis.tlast, axis.tkeep}, {53'h0, 1'b1, 1'b1, 1'b0, 8'hFF});
      pixel_data_i = 48'hFFF_FFF_106_105;
      tick();
      check("b_b1_tdata", axis.tdata, 64'h0000_0000_0106_0105);
      check("b_b1_user_last_keep", {axis.tuser, axis.tlast, axis.tkeep}, {54'h0, 1'b0, 1'b1, 8'h0F});
      pixel_vld = 1'b0;
      tick();
      check("b_line_err", line_err, 64'h0);
      check("b_line_count", line_count, 64'd1);
      frame_valid = 1'b0;
      tick(); tick();

      // Overflow: 17 beats into a 16-deep FIFO with the sink stalled
      axis.tready = 1'b0;
      frame_valid = 1'b1; new_frame = 1'b1; cameraSel = 1'b1; lineWidth = 16'd0;
      tick();
      new_frame = 1'b0; pixel_vld = 1'b1;
      for (int k = 0; k < 16; k++) begin
         pixel_data_i = px4(k);
         tick();
      end
      check("o_full_no_ovf", overflow, 64'h0);
      check("o_head_b0", axis.tdata, med_beat(0));
      check("o_head_user", axis.tuser, 64'h1);
      pixel_data_i = px4(16);
      tick();
      check("o_ovf_set", overflow, 64'h1);
      check("o_head_stable", axis.tdata, med_beat(0));
      check("o_no_tlast", axis.tlast, 64'h0);
      pixel_vld = 1'b0; axis.tready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         check("o_drain_valid", axis.tvalid, 64'h1);
         check("o_drain_data", axis.tdata, med_beat(k));
         tick();
      end
      check("o_drain_empty", axis.tvalid, 64'h0);
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      check("o_ovf_clear", overflow, 64'h0);
      frame_valid = 1'b0;
      tick();
      check("o_no_flush", axis.tvalid, 64'h0);
      check("o_no_line_err", line_err, 64'h0);
      tick();

      // Base mode, frame ends after one pixel group: flush a half beat
      frame_valid = 1'b1; new_frame = 1'b1; cameraSel = 1'b0; lineWidth = 16'd8;
      tick();
      new_frame = 1'b0; pixel_vld = 1'b1; pixel_data_i = 48'h000_000_202_201;
      tick();
      pixel_vld = 1'b0;
      check("f_held", axis.tvalid, 64'h0);
      frame_valid = 1'b0;
      tick();
      check("f_flush_tdata", axis.tdata, 64'h0000_0000_0202_0201);
      check("f_flush_user_last_keep", {axis.tvalid, axis.tuser, axis.tlast, axis.tkeep}, {53'h0, 1'b1, 1'b1, 1'b1, 8'h0F});
      check("f_line_err", line_err, 64'h1);
      check("f_fdone", frame_done, 64'h1);
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      check("f_popped", axis.tvalid, 64'h0);
      check("f_err_clear", line_err, 64'h0);

      // new_frame coincident with pixel_vld while a half beat is held
      frame_valid = 1'b1; new_frame = 1'b1; cameraSel = 1'b0; lineWidth = 16'd8;
      tick();
      new_frame = 1'b0; pixel_vld = 1'b1; pixel_data_i = 48'h000_000_302_301;
      tick();
      new_frame = 1'b1; clr_status = 1'b1; pixel_data_i = 48'h000_000_402_401;
      tick();
      new_frame = 1'b0; clr_status = 1'b0;
      check("n_discard_no_beat", axis.tvalid, 64'h0);
      check("n_line_err_over_clr", line_err, 64'h1);
      pixel_data_i = 48'h000_000_404_403;
      tick();
      pixel_vld = 1'b0;
      check("n_beat_tdata", axis.tdata, 64'h0404_0403_0402_0401);
      check("n_beat_user", {axis.tvalid, axis.tuser, axis.tlast}, 64'b110);
      check("n_line_count", line_count, 64'h0);
      tick();

      // Reset mid-line with three beats queued
      axis.tready = 1'b0; new_frame = 1'b1; cameraSel = 1'b1; lineWidth = 16'd8;
      tick();
      new_frame = 1'b0; pixel_vld = 1'b1;
      for (int k = 0; k < 3; k++) begin
         pixel_data_i = px4(k);
         tick();
      end
      pixel_vld = 1'b0;
      check("r_pre_tvalid", axis.tvalid, 64'h1);
      check("r_pre_line_count", line_count, 64'd1);
      sys_rst = 1'b1;
      #1;
      check("r_async_tvalid", axis.tvalid, 64'h0);
      check("r_async_line_count", line_count, 64'h0);
      check("r_async_line_err", line_err, 64'h0);
      frame_valid = 1'b0;
      tick(); tick();
      check("r_no_fdone_in_rst", frame_done, 64'h0);
      sys_rst = 1'b0;
      tick();
      check("r_no_fdone_after", frame_done, 64'h0);
      check("r_still_empty", axis.tvalid, 64'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
